crypto_cmd_scheduler: RTL

//  Buffers decoded SPI commands {opcode,key_addr,text_addr} from the deserializer and sequences each command through the crypto datapath.
//  Per command: key fetch (skipped for hash), text fetch, core run, result store, with a timeout watchdog on every wait.

---
 rtl/crypto_cmd_scheduler_pkg.sv | 35 +++
 rtl/crypto_cmd_scheduler_if.sv | 33 +++
 rtl/crypto_cmd_scheduler_cmd_fifo.sv | 42 ++++
 rtl/crypto_cmd_scheduler.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/crypto_cmd_scheduler_pkg.sv
// Shared opcodes, FSM encoding and small helpers for the crypto command scheduler.
package crypto_cmd_scheduler_pkg;

  localparam int ADDRW_DEF     = 8;
  localparam int OPCODEW_DEF   = 2;
  localparam int DEPTH_DEF     = 4;
  localparam int TIMEOUT_W_DEF = 10;

  localparam logic [1:0] OP_ENC  = 2'b00;
  localparam logic [1:0] OP_DEC  = 2'b01;
  localparam logic [1:0] OP_HASH = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_FETCH_KEY  = 4'd1,
    ST_WAIT_KEY   = 4'd2,
    ST_FETCH_TXT  = 4'd3,
    ST_WAIT_TXT   = 4'd4,
    ST_START      = 4'd5,
    ST_WAIT_CORE  = 4'd6,
    ST_STORE      = 4'd7,
    ST_WAIT_STORE = 4'd8
  } state_t;

  // IDLE and START never stall, so only the remaining states are watched.
  function automatic logic watched(state_t s);
    return (s != ST_IDLE) && (s != ST_START);
  endfunction

  function automatic logic is_req_state(state_t s);
    return (s == ST_FETCH_KEY) || (s == ST_FETCH_TXT) || (s == ST_STORE);
  endfunction

endpackage

// File: rtl/crypto_cmd_scheduler_if.sv
// Command, bus and core signals between the scheduler (master) and its environment (slave).
// cmd: a command moves on a cycle where cmd_valid && cmd_ready; bus: bus_req holds until a bus_ack pulse, bus_done pulses at completion.
interface crypto_cmd_scheduler_if #(
  parameter int ADDRW   = 8,
  parameter int OPCODEW = 2
);
  logic               cmd_valid;
  logic [OPCODEW-1:0] cmd_opcode;
  logic [ADDRW-1:0]   cmd_key;
  logic [ADDRW-1:0]   cmd_text;
  logic               cmd_ready;

  logic               bus_req;
  logic               bus_ack;
  logic               bus_we;
  logic               bus_sel;
  logic [ADDRW-1:0]   bus_addr;
  logic               bus_done;

  logic               core_start;
  logic [OPCODEW-1:0] core_mode;
  logic               core_done;

  modport master (
    input  cmd_valid, cmd_opcode, cmd_key, cmd_text, bus_ack, bus_done, core_done,
    output cmd_ready, bus_req, bus_we, bus_sel, bus_addr, core_start, core_mode
  );

  modport slave (
    output cmd_valid, cmd_opcode, cmd_key, cmd_text, bus_ack, bus_done, core_done,
    input  cmd_ready, bus_req, bus_we, bus_sel, bus_addr, core_start, core_mode
  );
endinterface

// File: rtl/crypto_cmd_scheduler_cmd_fifo.sv
// Command FIFO; pointers carry one extra wrap bit to tell full from empty.
module cmd_fifo #(
  parameter int W     = 18,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/crypto_cmd_scheduler.sv
// Queues SPI commands and walks each through key fetch, text fetch, core run and result store.
module crypto_cmd_scheduler
  import crypto_cmd_scheduler_pkg::*;
#(
  parameter int ADDRW     = ADDRW_DEF,
  parameter int OPCODEW   = OPCODEW_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int TIMEOUT_W = TIMEOUT_W_DEF
) (
  input  logic   clk,
  input  logic   rst,
  crypto_cmd_scheduler_if.master io,
  output logic   busy,
  output logic   cmd_done,
  output logic   err,
  output state_t dbg_state
);
  localparam int CMDW = OPCODEW + 2*ADDRW;

  state_t state, state_next;

  logic [CMDW-1:0]      head;
  logic [OPCODEW-1:0]   head_op;
  logic [ADDRW-1:0]     head_key, head_text;
  logic                 fifo_full, fifo_empty;
  logic                 pop;

  logic [OPCODEW-1:0]   cur_op;
  logic [ADDRW-1:0]     cur_key, cur_text;
  logic [ADDRW-1:0]     nxt_key, nxt_text;

  logic [TIMEOUT_W-1:0] wd;
  logic                 wd_max;
  logic                 set_err;
  logic                 finish;
  logic                 req_next;

  logic                 bus_req_q, bus_we_q, bus_sel_q, core_start_q, cmd_done_q, err_q;
  logic [ADDRW-1:0]     bus_addr_q;

  cmd_fifo #(.W(CMDW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (io.cmd_valid),
    .pop   (pop),
    .wdata ({io.cmd_opcode, io.cmd_key, io.cmd_text}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign {head_op, head_key, head_text} = head;
  assign wd_max = &wd;

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    set_err    = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head_op == OPCODEW'(OP_ENC) || head_op == OPCODEW'(OP_DEC))
            state_next = ST_FETCH_KEY;
          else if (head_op == OPCODEW'(OP_HASH))
            state_next = ST_FETCH_TXT;
          else
            set_err = 1'b1;
        end
      end
      // ack and done together count as ack followed by done: the wait state is skipped
      ST_FETCH_KEY:  if (io.bus_ack) state_next = io.bus_done ? ST_FETCH_TXT : ST_WAIT_KEY;
      ST_WAIT_KEY:   if (io.bus_done) state_next = ST_FETCH_TXT;
      ST_FETCH_TXT:  if (io.bus_ack) state_next = io.bus_done ? ST_START : ST_WAIT_TXT;
      ST_WAIT_TXT:   if (io.bus_done) state_next = ST_START;
      ST_START:      state_next = ST_WAIT_CORE;
      ST_WAIT_CORE:  if (io.core_done) state_next = ST_STORE;
      ST_STORE: begin
        if (io.bus_ack) begin
          state_next = io.bus_done ? ST_IDLE : ST_WAIT_STORE;
          finish     = io.bus_done;
        end
      end
      ST_WAIT_STORE: begin
        if (io.bus_done) begin
          state_next = ST_IDLE;
          finish     = 1'b1;
        end
      end
      default:       state_next = ST_IDLE;
    endcase
    // A real event in the same cycle wins over the watchdog.
    if (watched(state) && (state_next == state) && wd_max) begin
      state_next = ST_IDLE;
      set_err    = 1'b1;
    end
  end

  assign req_next = is_req_state(state_next);
  assign nxt_key  = pop ? head_key  : cur_key;
  assign nxt_text = pop ? head_text : cur_text;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      wd           <= '0;
      cur_op       <= '0;
      cur_key      <= '0;
      cur_text     <= '0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_sel_q    <= 1'b0;
      bus_addr_q   <= '0;
      core_start_q <= 1'b0;
      cmd_done_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next != state)
        wd <= '0;
      else if (watched(state))
        wd <= wd + TIMEOUT_W'(1);
      if (pop) begin
        cur_op   <= head_op;
        cur_key  <= head_key;
        cur_text <= head_text;
      end
      // Bus and core outputs are computed from the next state so they are valid in the state's own cycle.
      bus_req_q    <= req_next;
      bus_we_q     <= (state_next == ST_STORE);
      bus_sel_q    <= (state_next == ST_FETCH_TXT) || (state_next == ST_STORE);
      bus_addr_q   <= (state_next == ST_FETCH_KEY) ? nxt_key : (req_next ? nxt_text : '0);
      core_start_q <= (state_next == ST_START);
      cmd_done_q   <= finish;
      if (set_err) err_q <= 1'b1;
    end
  end

  assign io.cmd_ready  = !fifo_full;
  assign io.bus_req    = bus_req_q;
  assign io.bus_we     = bus_we_q;
  assign io.bus_sel    = bus_sel_q;
  assign io.bus_addr   = bus_addr_q;
  assign io.core_start = core_start_q;
  assign io.core_mode  = cur_op;

  assign busy      = (state != ST_IDLE) || !fifo_empty;
  assign cmd_done  = cmd_done_q;
  assign err       = err_q;
  assign dbg_state = state;
endmodule
